cb_config_loader: RTL and testbench

- Loads configuration bits into one connection block's switch-control vector (the transmission-gate enables `c`).
- Receives the bitstream as IW-bit words over a valid/ready stream and assembles them in a shadow register.
- Commits all CW bits to the live outputs in a single cycle, so the routing fabric never sees a partially written configuration.
- Sits between the fabric-level bitstream distributor and each connection block instance.

---
 rtl/cb_config_loader.sv | 145 ++++++++++++++
 tb/tb_cb_config_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_config_loader.sv
// Connection-block configuration loader: assembles IW-bit words into a shadow vector and commits all CW bits atomically.
// Optional macro CB_CFG_PARITY_EN adds per-word even parity (in_par) and a sticky par_err flag.
module cb_config_loader #(
  parameter int CW = 248,
  parameter int IW = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IW-1:0]                      in_data,
  input  logic                               in_last,
`ifdef CB_CFG_PARITY_EN
  input  logic                               in_par,
  output logic                               par_err,
`endif
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(((CW+IW-1)/IW)+1)-1:0] word_cnt,
  output logic [CW-1:0]                      c_out
);

  localparam int NW   = (CW + IW - 1) / IW;
  localparam int CNTW = $clog2(NW + 1);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CNTW-1:0] r_word_cnt;
  logic [CW-1:0]   r_c;
  logic            r_done;
  logic [CW-1:0]   w_shadow;
  logic            w_hs;
  logic            w_accept;
  logic            w_par_bad;
  logic            w_start_ok;

  assign w_hs       = (r_state == S_LOAD) && in_valid;
  // A word offered together with abort is consumed but never written.
  assign w_accept   = w_hs && !abort;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_ERR));

`ifdef CB_CFG_PARITY_EN
  logic r_par_err;
  assign w_par_bad = ((^in_data) != in_par);
  assign par_err   = r_par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else if (w_start_ok) begin
      r_par_err <= 1'b0;
    end else if (w_accept && w_par_bad) begin
      r_par_err <= 1'b1;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (in_valid) begin
          if (w_par_bad) begin
            w_state_next = S_ERR;
          end else if (r_word_cnt == LAST_IDX) begin
            w_state_next = in_last ? S_COMMIT : S_ERR;
          end else if (in_last) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_COMMIT: begin
        busy         = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        if (start) w_state_next = S_LOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_c        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) r_c <= w_shadow;
      if (w_start_ok) begin
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
    end
  end

  // One register per word slot; the top slot is narrower when CW is not a multiple of IW.
  for (genvar gi = 0; gi < NW; gi++) begin : g_slot
    localparam int LO = gi * IW;
    localparam int SW = ((CW - LO) < IW) ? (CW - LO) : IW;
    logic [SW-1:0] r_slot;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slot <= '0;
      end else if (w_accept && (r_word_cnt == CNTW'(gi))) begin
        r_slot <= in_data[SW-1:0];
      end
    end

    assign w_shadow[LO +: SW] = r_slot;
  end

  assign err      = (r_state == S_ERR);
  assign done     = r_done;
  assign word_cnt = r_word_cnt;
  assign c_out    = r_c;

endmodule

// File: tb/tb_cb_config_loader.sv
// Bench for cb_config_loader: table-driven frames, a commit scoreboard, and hand-written reset/parity sequences.
module tb_cb_config_loader;

  localparam int CW   = 248;
  localparam int IW   = 8;
  localparam int NW   = 31;
  localparam int CNTW = $clog2(NW + 1);

  typedef struct {
    logic [7:0] seed;
    logic [7:0] mul;
    int         nwords;
    int         last_idx;
    bit         stall;
    int         abort_idx;
    int         badpar_idx;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [IW-1:0]   in_data = '0;
  logic            in_ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [CNTW-1:0] word_cnt;
  logic [CW-1:0]   c_out;
`ifdef CB_CFG_PARITY_EN
  logic            in_par = 1'b0;
  logic            par_err;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] model_shadow = '0;
  logic [CW-1:0] model_c = '0;
  logic [CW-1:0] exp_q[$];
  logic          prev_done = 1'b0;
  vec_t          vecs[9];

  cb_config_loader #(.CW(CW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
`ifdef CB_CFG_PARITY_EN
    .in_par   (in_par),
    .par_err  (par_err),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt),
    .c_out    (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width actual=2+ cycles required=1 cycle");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        if (c_out !== e) begin
          errors++;
          $display("FAIL commit_c_out actual=%0h required=%0h", c_out, e);
        end
      end
    end
    prev_done <= done;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic drive_word(input logic [IW-1:0] d, input bit last, input bit ab);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    abort    = ab;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL handshake_timeout actual in_ready=0 required=1");
    end
    check("mid_frame_c_out", c_out, model_c);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic run_frame(input int id, input vec_t v);
    int acc;
    acc = 0;
    pulse_start();
    for (int k = 0; k < v.nwords; k++) begin
      logic [IW-1:0] d;
      d = v.seed + 8'(k) * v.mul;
`ifdef CB_CFG_PARITY_EN
      in_par = (^d) ^ (k == v.badpar_idx);
`endif
      drive_word(d, k == v.last_idx, k == v.abort_idx);
      if (k != v.abort_idx) begin
        model_shadow[k*IW +: IW] = d;
        acc++;
      end
      if (v.stall && (k != v.nwords - 1)) begin
        @(negedge clk);
        check("stall_in_ready", in_ready, 1);
        @(posedge clk); #1;
      end
    end
    if (v.exp_done) exp_q.push_back(model_shadow);
    @(negedge clk);
    if (v.exp_done) begin
      check("commit_busy", busy, 1);
      check("commit_in_ready", in_ready, 0);
      check("commit_done_early", done, 0);
      @(negedge clk);
      check("done_pulse", done, 1);
      model_c = model_shadow;
    end else if (v.exp_err) begin
      check("err_flag", err, 1);
      check("err_in_ready", in_ready, 0);
      check("err_busy", busy, 0);
    end else begin
      check("abort_busy", busy, 0);
      check("abort_err", err, 0);
      check("abort_in_ready", in_ready, 0);
    end
    @(negedge clk);
    check("done_low", done, 0);
    check("c_out_live", c_out, model_c);
    check("err_state", err, v.exp_err);
    check("word_cnt", word_cnt, acc);
    check("busy_low", busy, 0);
`ifdef CB_CFG_PARITY_EN
    check("par_err", par_err, (v.badpar_idx >= 0) ? 1 : 0);
`endif
    $display("row %0d seed=%h words=%0d stall=%0b abort=%0d badpar=%0d done_exp=%0b err=%0b word_cnt=%0d c_out=%h",
             id, v.seed, v.nwords, v.stall, v.abort_idx, v.badpar_idx, v.exp_done, err, word_cnt, c_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h00, 31, 30, 1'b0, -1, -1, 1'b1, 1'b0};
    vecs[1] = '{8'h11, 8'h07, 31, 30, 1'b1, -1, -1, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 8'h01, 11, 10, 1'b0, -1, -1, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 8'h00, 31, 30, 1'b0, -1, -1, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 8'h05, 31, -1, 1'b0, -1, -1, 1'b0, 1'b1};
    vecs[5] = '{8'h77, 8'h03, 31, 30, 1'b0, -1, -1, 1'b1, 1'b0};
    vecs[6] = '{8'h99, 8'h02, 31, 30, 1'b0, 30, -1, 1'b0, 1'b0};
    vecs[7] = '{8'hF0, 8'h01, 31, 30, 1'b1, -1, -1, 1'b1, 1'b0};
    vecs[8] = '{8'h2D, 8'h09, 31, 30, 1'b0, -1, -1, 1'b1, 1'b0};

    @(negedge clk);
    check("reset_c_out", c_out, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_word_cnt", word_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(i, vecs[i]);
      if (i == 0) check("a5_pattern", c_out, {31{8'hA5}});
      if (i == 3) check("3c_pattern", c_out, {31{8'h3C}});
    end

    // Asynchronous reset while word 15 is being offered.
    pulse_start();
    for (int k = 0; k < 15; k++) begin
      logic [IW-1:0] d;
      d = 8'h80 + 8'(k);
`ifdef CB_CFG_PARITY_EN
      in_par = ^d;
`endif
      drive_word(d, 1'b0, 1'b0);
      model_shadow[k*IW +: IW] = d;
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    #2 rst = 1'b1;
    #1;
    check("rst_c_out", c_out, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_word_cnt", word_cnt, 0);
    in_valid     = 1'b0;
    model_c      = '0;
    model_shadow = '0;
    $display("row async_reset c_out=%h", c_out);
    @(posedge clk); #1 rst = 1'b0;

    run_frame(8, vecs[8]);

`ifdef CB_CFG_PARITY_EN
    begin
      vec_t pv;
      pv = '{8'h44, 8'h01, 6, -1, 1'b0, -1, 5, 1'b0, 1'b1};
      run_frame(9, pv);
      pv = '{8'h66, 8'h01, 31, 30, 1'b0, -1, -1, 1'b1, 1'b0};
      run_frame(10, pv);
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", CW'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
